// File: rtl/shifter_operand_unit_pkg.sv
// Shared encodings and bundles for the ARM operand-2 shifter.
// Imported by the decode sub-module and the top level.
package shifter_pkg;

    localparam int WIDTH = 32;
    localparam int AMT_W = 8;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] CLAMP32 = 6'd32;
    localparam logic [CNT_W-1:0] CLAMP33 = 6'd33;

    typedef enum logic [1:0] {
        MODE_ROT_IMM = 2'b00,
        MODE_IMM_SH  = 2'b01,
        MODE_REG_SH  = 2'b10,
        MODE_PASS    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] n;
        logic             left;
        logic             arith;
        logic             rot;
        logic             rrx;
        logic [WIDTH-1:0] value;
        logic             carry;
    } plan_t;

endpackage

// File: rtl/shifter_operand_unit_if.sv
// Request/result bundle between decode control and the operand-2 shifter.
// master = control side, slave = shifter side.
interface shifter_operand_unit_if;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  shift_type;
    logic [7:0]  imm8;
    logic [3:0]  rot;
    logic [4:0]  shamt;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        cin;
    logic [31:0] operand2;
    logic        shifter_carry;
    logic        busy;
    logic        done;

    modport master (
        output start, mode, shift_type, imm8, rot, shamt, rm, rs, cin,
        input  operand2, shifter_carry, busy, done
    );

    modport slave (
        input  start, mode, shift_type, imm8, rot, shamt, rm, rs, cin,
        output operand2, shifter_carry, busy, done
    );
endinterface

// File: rtl/shifter_operand_unit_shift_amount_decode.sv
// Maps mode, shift type and amount fields to an iteration plan:
// count, shift direction/fill flags, starting value and starting carry.
module shift_amount_decode
    import shifter_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot,
    input  logic [4:0]  shamt,
    input  logic [31:0] rm,
    input  logic [7:0]  rs,
    input  logic        cin,
    output plan_t       plan
);

    always_comb begin
        plan       = '0;
        plan.value = rm;
        plan.carry = cin;
        plan.left  = (shift_type == SH_LSL);
        plan.arith = (shift_type == SH_ASR);
        plan.rot   = (shift_type == SH_ROR);
        case (mode)
            MODE_ROT_IMM: begin
                plan.value = {24'b0, imm8};
                plan.left  = 1'b0;
                plan.arith = 1'b0;
                plan.rot   = 1'b1;
                plan.n     = {1'b0, rot, 1'b0};
            end
            MODE_IMM_SH: begin
                if (shamt != 5'd0) begin
                    plan.n = {1'b0, shamt};
                end else begin
                    // Zero encodes LSR/ASR #32 and RRX; LSL #0 is a pass-through
                    case (shift_type)
                        SH_LSR, SH_ASR: plan.n = CLAMP32;
                        SH_ROR: begin
                            plan.n   = 6'd1;
                            plan.rot = 1'b0;
                            plan.rrx = 1'b1;
                        end
                        default: plan.n = '0;
                    endcase
                end
            end
            MODE_REG_SH: begin
                if (rs != 8'd0) begin
                    case (shift_type)
                        SH_LSL, SH_LSR:
                            plan.n = (rs >= 8'(CLAMP33)) ? CLAMP33 : rs[5:0];
                        SH_ASR:
                            plan.n = (rs >= 8'(CLAMP32)) ? CLAMP32 : rs[5:0];
                        default: begin
                            plan.n = {1'b0, rs[4:0]};
                            if (rs[4:0] == 5'd0) plan.carry = rm[31];
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shifter_operand_unit.sv
// Iterative operand-2 shifter: one bit per cycle, start/busy/done handshake.
// The result and carry registers only change on the cycle entering DONE.
module shifter_operand_unit
    import shifter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    shifter_operand_unit_if.slave bus
);

    state_e           state;
    state_e           state_nxt;
    plan_t            plan;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] sh_value;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic             sh_carry;
    logic             fill;
    logic             left;
    logic             arith;
    logic             rot;
    logic             rrx;
    logic             accept;
    logic [WIDTH-1:0] operand2;
    logic             shifter_carry;

    shift_amount_decode u_decode (
        .mode       (bus.mode),
        .shift_type (bus.shift_type),
        .imm8       (bus.imm8),
        .rot        (bus.rot),
        .shamt      (bus.shamt),
        .rm         (bus.rm),
        .rs         (bus.rs),
        .cin        (bus.cin),
        .plan       (plan)
    );

    assign accept            = bus.start && (state != ST_SHIFT);
    assign bus.busy          = (state == ST_SHIFT);
    assign bus.done          = (state == ST_DONE);
    assign bus.operand2      = operand2;
    assign bus.shifter_carry = shifter_carry;

    // RRX fills with the carry register, which was loaded with CIN
    always_comb begin
        fill = 1'b0;
        if (rrx)        fill = carry;
        else if (rot)   fill = value[0];
        else if (arith) fill = value[31];
        if (left) begin
            sh_value = {value[30:0], 1'b0};
            sh_carry = value[31];
        end else begin
            sh_value = {fill, value[31:1]};
            sh_carry = value[0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = (plan.n == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (count == 6'd1) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (accept) state_nxt = (plan.n == '0) ? ST_DONE : ST_SHIFT;
                else        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value         <= '0;
            count         <= '0;
            carry         <= 1'b0;
            left          <= 1'b0;
            arith         <= 1'b0;
            rot           <= 1'b0;
            rrx           <= 1'b0;
            operand2      <= '0;
            shifter_carry <= 1'b0;
        end else if (accept) begin
            value <= plan.value;
            count <= plan.n;
            carry <= plan.carry;
            left  <= plan.left;
            arith <= plan.arith;
            rot   <= plan.rot;
            rrx   <= plan.rrx;
            if (plan.n == '0) begin
                operand2      <= plan.value;
                shifter_carry <= plan.carry;
            end
        end else if (state == ST_SHIFT) begin
            value <= sh_value;
            carry <= sh_carry;
            count <= count - 6'd1;
            if (count == 6'd1) begin
                operand2      <= sh_value;
                shifter_carry <= sh_carry;
            end
        end
    end

endmodule
